operand_feeder: RTL and testbench
=================================

# operand_feeder

Upstream stage of the matrix-multiply `top`: walks A (M×N) and B (N×K) stored row-major in two single-port read memories and emits the interleaved operand stream that `top` consumes on `A_in/A_valid_in` and `B_in/B_valid_in`. For every output tile (Si rows × Sj columns of C) and every reduction index n, it emits Si consecutive A beats (column n of the tile's A rows), then Sj consecutive B beats (row n of the tile's B columns). The stream has no gaps and no backpressure.

## Interface
Parameters:
- `DATA_WIDTH`, 64: operand width.
- `A_NUM_WIDTH`, 3: log2(Si), rows per tile.
- `B_NUM_WIDTH`, 3: log2(Sj), columns per tile.
- `N_MAX_WIDTH`, 32: width of the dimension inputs.
- `ADDR_WIDTH`, 16: memory address width.

Ports:
- `clk`  in  1  clock; all logic on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle request; sampled only in IDLE.
- `M_in`, `N_in`, `K_in`  in  N_MAX_WIDTH  dimensions; captured on accepted `start`.
- `A_base`, `B_base`  in  ADDR_WIDTH  base addresses; captured on accepted `start`.
- `A_rd_en`, `A_rd_addr`  out  1 / ADDR_WIDTH  A memory read request.
- `A_rd_data`  in  DATA_WIDTH  A read data, valid exactly 1 cycle after `A_rd_en`.
- `B_rd_en`, `B_rd_addr`, `B_rd_data`  out/out/in  B memory port; same timing as A.
- `A_out`, `A_valid_out`  out  DATA_WIDTH / 1  connects to `top.A_in/A_valid_in`.
- `B_out`, `B_valid_out`  out  DATA_WIDTH / 1  connects to `top.B_in/B_valid_in`.
- `busy`  out  1  high while a job runs.
- `done`  out  1  one-cycle pulse at job end.

## Operation
- Si = 2^A_NUM_WIDTH and Sj = 2^B_NUM_WIDTH. Tile counts: TM = M_in>>A_NUM_WIDTH and TK = K_in>>B_NUM_WIDTH. The low bits of M_in and K_in are ignored.
- `start` is accepted only in IDLE, and only if TM, TK and N_in are all nonzero. Otherwise it is ignored: no state change, no `done`. `start` while busy is ignored.
- FSM states:
  - IDLE → A_PH on accepted start.
  - A_PH: issue Si A reads. Last read → B_PH.
  - B_PH: issue Sj B reads. On the last read: if (i,j,n) is final → DRAIN; else advance the counters → A_PH.
  - DRAIN: one cycle, the last B beat is emitted → FIN.
  - FIN: `done`=1 → IDLE.
- Loop order, outermost first: i ∈ [0,TM), j ∈ [0,TK), n ∈ [0,N), then ii ∈ [0,Si) in A_PH, then jj ∈ [0,Sj) in B_PH.
- A address = A_base + (i·Si+ii)·N + n.
- B address = B_base + n·K + j·Sj+jj.
- All address arithmetic is modulo 2^ADDR_WIDTH. Running-pointer increments are preferred over multipliers, but the results must match these formulas exactly.
- Exactly one of `A_rd_en`/`B_rd_en` is high in every A_PH/B_PH cycle. Both are low otherwise.
- `A_out` ← `A_rd_data` and `A_valid_out` ← `A_rd_en`, both delayed by the 1-cycle memory latency; B likewise.
- `A_out`/`B_out` hold their last value when not valid.
- Total beats per job = TM·TK·N·(Si+Sj).

## Timing
- Reset (async assert, sync release): FSM=IDLE, all counters 0, and `A_rd_en`=`B_rd_en`=`A_valid_out`=`B_valid_out`=`busy`=`done`=0. `A_rd_addr`/`B_rd_addr`/`A_out`/`B_out` reset to 0.
- Reset mid-job aborts immediately: no `done`, and no valid beat follows release.
- `start` accepted at edge 0 → first `A_rd_en` in cycle 1 → first `A_valid_out` in cycle 2.
- Let L = total beats. The last read is in cycle L, the last `B_valid_out` is in cycle L+1, and `done` is high in cycle L+2.
- `busy` is high from cycle 1 through cycle L+2 inclusive. It drops together with `done` at the next edge.
- A new `start` is accepted at the earliest in the cycle after `done`.
- A→B and B→A phase switches are back-to-back, with no idle cycle.

## Test plan
- **Single tile:** M=N=K=8, Si=Sj=8, A_base=0, B_base=0x100, start at cycle 0.
  - A addresses in cycles 1..8: 0,8,…,56. B addresses in cycles 9..16: 0x100..0x107. Next A addresses: 1,9,…,57.
  - 128 beats; `done` at cycle 130.
- **16×16×16 with Si=Sj=8** (memories hold A[r][c]=r·16+c):
  - 1024 beats; `done` at cycle 1026.
  - The sequence of `A_out` values equals the A_matrix[i·8+ii][n] order of top_tb's stimulus; B likewise.
- **Zero or short dimensions:** N_in=0, or M_in=7 (TM=0) → start ignored, `busy` stays 0, no read issued.
- **Start while busy:** a second `start` pulse at cycle 50 of a running job → no effect; the beat count and `done` cycle are unchanged.
- **Reset mid-job:** assert `rst_n`=0 at cycle 40 → all valids, `busy` and `done` go 0 asynchronously. After release, a new start restarts from address A_base.
- **Address wrap:** ADDR_WIDTH=8, A_base=0xFC, N=8 → A addresses 0xFC, 0x04, 0x0C, … (modulo 256).

Source files
------------

// File: rtl/operand_feeder.sv
// operand_feeder
//   Walks row-major A (M x N) and B (N x K) through two single-port read
//   memories and emits the operand stream for the matrix-multiply core.
//   For each output tile (i, j) and each reduction index n, Si A beats are
//   emitted (column n of the tile's A rows), followed by Sj B beats (row n of
//   the tile's B columns). The stream has no gaps and no backpressure.
// Ports
//   clk, rst_n               clock, asynchronous active-low reset
//   start                    one-cycle job request, honoured only when idle
//   M_in, N_in, K_in         matrix dimensions, captured on accepted start
//   A_base, B_base           memory base addresses, captured on accepted start
//   A_rd_en/A_rd_addr/A_rd_data  A memory port (1-cycle read latency)
//   B_rd_en/B_rd_addr/B_rd_data  B memory port (1-cycle read latency)
//   A_out/A_valid_out        A operand stream
//   B_out/B_valid_out        B operand stream
//   busy                     high while a job runs
//   done                     one-cycle pulse at job end
module operand_feeder #(
  parameter int DATA_WIDTH  = 64,
  parameter int A_NUM_WIDTH = 3,
  parameter int B_NUM_WIDTH = 3,
  parameter int N_MAX_WIDTH = 32,
  parameter int ADDR_WIDTH  = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [N_MAX_WIDTH-1:0] M_in,
  input  logic [N_MAX_WIDTH-1:0] N_in,
  input  logic [N_MAX_WIDTH-1:0] K_in,
  input  logic [ADDR_WIDTH-1:0]  A_base,
  input  logic [ADDR_WIDTH-1:0]  B_base,
  output logic                   A_rd_en,
  output logic [ADDR_WIDTH-1:0]  A_rd_addr,
  input  logic [DATA_WIDTH-1:0]  A_rd_data,
  output logic                   B_rd_en,
  output logic [ADDR_WIDTH-1:0]  B_rd_addr,
  input  logic [DATA_WIDTH-1:0]  B_rd_data,
  output logic [DATA_WIDTH-1:0]  A_out,
  output logic                   A_valid_out,
  output logic [DATA_WIDTH-1:0]  B_out,
  output logic                   B_valid_out,
  output logic                   busy,
  output logic                   done
);

  typedef enum logic [2:0] {S_IDLE, S_A_PH, S_B_PH, S_DRAIN, S_FIN} state_t;

  localparam logic [ADDR_WIDTH-1:0]  SJ_STEP = ADDR_WIDTH'(1 << B_NUM_WIDTH);
  localparam logic [N_MAX_WIDTH-1:0] ONE     = N_MAX_WIDTH'(1);

  state_t state_q, state_d;

  logic [N_MAX_WIDTH-1:0] tm_q, tk_q, nn_q;
  logic [N_MAX_WIDTH-1:0] i_q, j_q, n_q;
  logic [A_NUM_WIDTH-1:0] ii_q;
  logic [B_NUM_WIDTH-1:0] jj_q;

  // Running pointers replace the address multipliers:
  //   a_blk_q  = A_base + i*Si*N         a_row0_q = a_blk_q + n
  //   a_ptr_q  = a_row0_q + ii*N
  //   b_col0_q = B_base + j*Sj           b_row0_q = b_col0_q + n*K
  //   b_ptr_q  = b_row0_q + jj
  logic [ADDR_WIDTH-1:0] n_step_q, k_step_q, b_base_q;
  logic [ADDR_WIDTH-1:0] a_blk_q, a_row0_q, a_ptr_q;
  logic [ADDR_WIDTH-1:0] b_col0_q, b_row0_q, b_ptr_q;

  logic [N_MAX_WIDTH-1:0] tm_in, tk_in;
  logic start_ok, a_last, b_last, n_last, j_last, i_last, job_last;

  logic                  a_valid_q, b_valid_q;
  logic [DATA_WIDTH-1:0] a_hold_q, b_hold_q;

  always_comb begin
    tm_in    = M_in >> A_NUM_WIDTH;
    tk_in    = K_in >> B_NUM_WIDTH;
    start_ok = start && (tm_in != '0) && (tk_in != '0) && (N_in != '0);
    a_last   = (ii_q == '1);
    b_last   = (jj_q == '1);
    n_last   = (n_q == nn_q - ONE);
    j_last   = (j_q == tk_q - ONE);
    i_last   = (i_q == tm_q - ONE);
    job_last = i_last && j_last && n_last;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    A_rd_en = 1'b0;
    B_rd_en = 1'b0;
    busy    = 1'b1;
    done    = 1'b0;
    case (state_q)
      S_IDLE: begin
        busy = 1'b0;
        if (start_ok) state_d = S_A_PH;
      end
      S_A_PH: begin
        A_rd_en = 1'b1;
        if (a_last) state_d = S_B_PH;
      end
      S_B_PH: begin
        B_rd_en = 1'b1;
        if (b_last) state_d = job_last ? S_DRAIN : S_A_PH;
      end
      S_DRAIN: state_d = S_FIN;
      S_FIN: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign A_rd_addr = a_ptr_q;
  assign B_rd_addr = b_ptr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tm_q     <= '0;
      tk_q     <= '0;
      nn_q     <= '0;
      i_q      <= '0;
      j_q      <= '0;
      n_q      <= '0;
      ii_q     <= '0;
      jj_q     <= '0;
      n_step_q <= '0;
      k_step_q <= '0;
      b_base_q <= '0;
      a_blk_q  <= '0;
      a_row0_q <= '0;
      a_ptr_q  <= '0;
      b_col0_q <= '0;
      b_row0_q <= '0;
      b_ptr_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: if (start_ok) begin
          tm_q     <= tm_in;
          tk_q     <= tk_in;
          nn_q     <= N_in;
          i_q      <= '0;
          j_q      <= '0;
          n_q      <= '0;
          ii_q     <= '0;
          jj_q     <= '0;
          n_step_q <= ADDR_WIDTH'(N_in);
          k_step_q <= ADDR_WIDTH'(K_in);
          b_base_q <= B_base;
          a_blk_q  <= A_base;
          a_row0_q <= A_base;
          a_ptr_q  <= A_base;
          b_col0_q <= B_base;
          b_row0_q <= B_base;
          b_ptr_q  <= B_base;
        end
        S_A_PH: begin
          ii_q <= ii_q + 1'b1;
          if (!a_last) a_ptr_q <= a_ptr_q + n_step_q;
        end
        S_B_PH: begin
          jj_q <= jj_q + 1'b1;
          if (!b_last) begin
            b_ptr_q <= b_ptr_q + 1'b1;
          end else if (!job_last) begin
            // Next A/B phase starts on the following cycle, so both pointers
            // are loaded with the first address of the next (i, j, n) step.
            if (!n_last) begin
              n_q      <= n_q + ONE;
              a_row0_q <= a_row0_q + 1'b1;
              a_ptr_q  <= a_row0_q + 1'b1;
              b_row0_q <= b_row0_q + k_step_q;
              b_ptr_q  <= b_row0_q + k_step_q;
            end else if (!j_last) begin
              n_q      <= '0;
              j_q      <= j_q + ONE;
              a_row0_q <= a_blk_q;
              a_ptr_q  <= a_blk_q;
              b_col0_q <= b_col0_q + SJ_STEP;
              b_row0_q <= b_col0_q + SJ_STEP;
              b_ptr_q  <= b_col0_q + SJ_STEP;
            end else begin
              n_q      <= '0;
              j_q      <= '0;
              i_q      <= i_q + ONE;
              a_blk_q  <= a_blk_q + (n_step_q << A_NUM_WIDTH);
              a_row0_q <= a_blk_q + (n_step_q << A_NUM_WIDTH);
              a_ptr_q  <= a_blk_q + (n_step_q << A_NUM_WIDTH);
              b_col0_q <= b_base_q;
              b_row0_q <= b_base_q;
              b_ptr_q  <= b_base_q;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Read data arrives one cycle after the request; outputs pass it through
  // while valid and otherwise hold the last delivered operand.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_valid_q <= 1'b0;
      b_valid_q <= 1'b0;
      a_hold_q  <= '0;
      b_hold_q  <= '0;
    end else begin
      a_valid_q <= A_rd_en;
      b_valid_q <= B_rd_en;
      if (a_valid_q) a_hold_q <= A_rd_data;
      if (b_valid_q) b_hold_q <= B_rd_data;
    end
  end

  always_comb begin
    A_valid_out = a_valid_q;
    B_valid_out = b_valid_q;
    A_out       = a_valid_q ? A_rd_data : a_hold_q;
    B_out       = b_valid_q ? B_rd_data : b_hold_q;
  end

endmodule

// File: tb/tb_operand_feeder.sv
module tb_operand_feeder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] M_in, N_in, K_in;
  logic [15:0] A_base, B_base;
  logic        A_rd_en, B_rd_en;
  logic [15:0] A_rd_addr, B_rd_addr;
  logic [63:0] A_rd_data, B_rd_data;
  logic [63:0] A_out, B_out;
  logic        A_valid_out, B_valid_out, busy, done;

  int total = 0;
  int bad   = 0;
  int beats_seen = 0;
  logic [64:0] exp_q[$];   // {is_b, data}
  logic [63:0] last_a, last_b;

  operand_feeder #(
    .DATA_WIDTH (64),
    .A_NUM_WIDTH(3),
    .B_NUM_WIDTH(3),
    .N_MAX_WIDTH(32),
    .ADDR_WIDTH (16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .M_in(M_in), .N_in(N_in), .K_in(K_in),
    .A_base(A_base), .B_base(B_base),
    .A_rd_en(A_rd_en), .A_rd_addr(A_rd_addr), .A_rd_data(A_rd_data),
    .B_rd_en(B_rd_en), .B_rd_addr(B_rd_addr), .B_rd_data(B_rd_data),
    .A_out(A_out), .A_valid_out(A_valid_out),
    .B_out(B_out), .B_valid_out(B_valid_out),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Memory contents encode the address, so a data match proves the address.
  function automatic logic [63:0] mem_a(input logic [15:0] a);
    return {16'hA5A5, a, a ^ 16'h3C3C, ~a};
  endfunction
  function automatic logic [63:0] mem_b(input logic [15:0] a);
    return {16'hB00B, ~a, a, a ^ 16'h5A5A};
  endfunction

  // 1-cycle latency memories; random garbage when not read, to expose
  // outputs that fail to hold.
  always @(posedge clk) begin
    A_rd_data <= A_rd_en ? mem_a(A_rd_addr) : {$urandom, $urandom};
    B_rd_data <= B_rd_en ? mem_b(B_rd_addr) : {$urandom, $urandom};
  end

  function automatic void chk(input string name, input logic [63:0] act,
                              input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endfunction

  // Monitor: pops the scoreboard on every presented beat.
  always @(negedge clk) begin
    logic [64:0] e;
    if (!rst_n) begin
      last_a = '0;
      last_b = '0;
    end else begin
      if (A_rd_en && B_rd_en) chk("rd_en_exclusive", 1, 0);
      if (A_valid_out || B_valid_out) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", {A_valid_out, B_valid_out}, 0);
        end else begin
          e = exp_q.pop_front();
          chk("beat_kind", {62'd0, A_valid_out, B_valid_out},
              e[64] ? 64'd1 : 64'd2);
          chk("beat_data", e[64] ? B_out : A_out, e[63:0]);
          beats_seen++;
        end
      end
      if (A_valid_out) last_a = A_out;
      else             chk("a_hold", A_out, last_a);
      if (B_valid_out) last_b = B_out;
      else             chk("b_hold", B_out, last_b);
    end
  end

  // mode 0: plain job, 1: extra start pulse while busy, 2: reset at cycle 40
  task automatic run_job(input int m, input int n, input int k,
                         input logic [15:0] ab, input logic [15:0] bb,
                         input int mode);
    int tm, tk, len, c, done_c, busy_c, first_busy, done_cnt, rd_seen, budget;
    bit acc;
    tm  = m >> 3;
    tk  = k >> 3;
    acc = (tm != 0) && (tk != 0) && (n != 0);
    len = acc ? tm * tk * n * 16 : 0;
    if (acc)
      for (int i = 0; i < tm; i++)
        for (int j = 0; j < tk; j++)
          for (int nn = 0; nn < n; nn++) begin
            for (int ii = 0; ii < 8; ii++)
              exp_q.push_back({1'b0, mem_a(16'(int'(ab) + (i*8 + ii)*n + nn))});
            for (int jj = 0; jj < 8; jj++)
              exp_q.push_back({1'b1, mem_b(16'(int'(bb) + nn*k + j*8 + jj))});
          end
    beats_seen = 0;
    @(negedge clk);
    M_in = 32'(m); N_in = 32'(n); K_in = 32'(k);
    A_base = ab; B_base = bb; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    c = 1; done_c = -1; busy_c = 0; first_busy = -1; done_cnt = 0; rd_seen = 0;
    budget = len + 12;
    while (c <= budget) begin
      if (busy) begin
        busy_c++;
        if (first_busy < 0) first_busy = c;
      end
      if (done) begin
        done_cnt++;
        if (done_c < 0) done_c = c;
      end
      if (A_rd_en || B_rd_en) rd_seen++;
      if (mode == 1 && c == 50) begin
        start = 1'b1; M_in = 32; N_in = 2; K_in = 32; A_base = 16'h7777;
      end
      if (mode == 1 && c == 51) start = 1'b0;
      if (mode == 2 && c == 40) begin
        rst_n = 1'b0;
        #1;
        chk("reset_async_ctl",
            {58'd0, busy, done, A_valid_out, B_valid_out, A_rd_en, B_rd_en}, 0);
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        busy_c = 0;
        repeat (8) begin
          @(negedge clk);
          if (busy || done || A_rd_en || B_rd_en) busy_c++;
        end
        chk("post_reset_idle", busy_c, 0);
        return;
      end
      if (done_c >= 0 && c >= done_c + 2) break;
      @(negedge clk);
      c++;
    end
    if (acc) begin
      chk("done_cycle", done_c, len + 2);
      chk("busy_cycles", busy_c, len + 2);
      chk("first_busy", first_busy, 1);
      chk("done_pulses", done_cnt, 1);
      chk("reads", rd_seen, len);
      chk("beats", beats_seen, len);
      chk("queue_empty", exp_q.size(), 0);
    end else begin
      chk("rej_busy", busy_c, 0);
      chk("rej_reads", rd_seen, 0);
      chk("rej_done", done_cnt, 0);
    end
    exp_q.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0;
    M_in = '0; N_in = '0; K_in = '0; A_base = '0; B_base = '0;
    repeat (3) @(negedge clk);
    chk("reset_ctl",
        {58'd0, busy, done, A_valid_out, B_valid_out, A_rd_en, B_rd_en}, 0);
    chk("reset_a_addr", A_rd_addr, 0);
    chk("reset_b_addr", B_rd_addr, 0);
    chk("reset_a_out", A_out, 0);
    chk("reset_b_out", B_out, 0);
    rst_n = 1'b1;

    run_job(8, 8, 8, 16'h0000, 16'h0100, 0);     // single tile, L=128
    run_job(16, 16, 16, 16'h0000, 16'h0400, 0);  // L=1024
    run_job(8, 0, 8, 16'h0010, 16'h0020, 0);     // N=0 rejected
    run_job(7, 8, 8, 16'h0010, 16'h0020, 0);     // TM=0 rejected
    run_job(8, 4, 7, 16'h0010, 16'h0020, 0);     // TK=0 rejected
    run_job(16, 8, 16, 16'h0020, 16'h0300, 1);   // start while busy
    run_job(16, 8, 16, 16'h0040, 16'h0500, 2);   // reset mid-job
    run_job(8, 4, 8, 16'h0040, 16'h0500, 0);     // restart after reset
    run_job(8, 8, 8, 16'hFFFC, 16'hFFFA, 0);     // address wrap
    for (int r = 0; r < 3; r++)
      run_job($urandom_range(8, 23), $urandom_range(1, 4), $urandom_range(8, 23),
              16'($urandom), 16'($urandom), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
